load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-side responder for the pipeline's load/store path. Sits between the execute/memory stage (driven by control_unit) and the data memory bus.
- Accepts one load/store request at a time, runs a request/acknowledge transaction on the memory bus, and aligns the data: byte/halfword lane selection, sign/zero extension, write strobes.
- Returns a one-cycle completion pulse, which drives control_unit's load_type_in to release the load stall.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ack before aborting with error (≥2).
- RESET_DATA, 32'h0000_0000: reset/abort value of load_data.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present from pipeline
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data (rs2)
- load_done  output  1  one-cycle completion pulse (to control_unit load_type_in)
- load_data  output  32  extended load result, valid while load_done=1
- bus_err  output  1  error flag, valid while load_done=1
- mem_req  output  1  memory request, held until acked
- mem_we  output  1  memory write enable
- mem_addr  output  32  word address, bits[1:0]=00
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte write strobes (0000 on loads)
- mem_ack  input  1  memory accepted/completed request
- mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; req_ready=1 from the first cycle after reset.
  - load_done=0, bus_err=0, load_data=RESET_DATA.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- FSM: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - On req_valid&req_ready, capture we, funct3, addr, wdata.
  - Legal ops: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
  - Illegal funct3 -> DONE with bus_err=1 and no bus access.
  - Misaligned access (see Optional Feature).
  - Otherwise drive the bus registers and go to WAIT.
- WAIT:
  - mem_req=1 and all mem_* outputs held stable until mem_ack is sampled high.
  - On mem_ack, loads register the extracted data; go to DONE; mem_req drops on the next edge.
  - Timeout counter clears on entry and increments each WAIT cycle without ack. At count TIMEOUT-1 with no ack: go to DONE, bus_err=1, load_data=RESET_DATA.
  - mem_ack in the same cycle as the timeout takes priority: normal completion.
- DONE:
  - load_done=1 for exactly one cycle, then IDLE. req_ready=0.
  - For stores, load_data=RESET_DATA.
- Latency: accept at edge N -> mem_req high in cycle N+1 -> ack in cycle N+1 -> load_done in cycle N+2. Minimum 2 cycles; each extra ack-wait cycle adds 1.
- Store formatting:
  - SB: mem_wstrb=0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - SH: mem_wstrb=0011<<(2*addr[1]); mem_wdata={2{wdata[15:0]}}.
  - SW: mem_wstrb=1111; mem_wdata=wdata.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_addr = {addr[31:2],2'b00}.
- Boundary conditions:
  - req_valid while not IDLE: ignored, not queued.
  - Stray mem_ack in IDLE/DONE: ignored.
  - Reset during WAIT: mem_req drops at that edge; a late ack is ignored.
  - Address 32'hFFFF_FFFF: no wrap arithmetic performed.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, produce no bus access; IDLE->DONE directly, bus_err=1, load_data=RESET_DATA.
- Undefined: misalignment is not checked. Low address bits are ignored beyond lane selection: halfword uses addr[1], word uses lane 0. The access proceeds normally with bus_err=0.

Test Plan:
- Reset held 2 cycles, then released -> req_ready=1, mem_req=0, load_done=0, load_data=0.
- LW addr=0x100, mem_ack same cycle as mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_wstrb=0000; load_done high exactly 2 cycles after accept; load_data=0xDEADBEEF, bus_err=0.
- LB addr=0x103, rdata=0x80FF_0000 -> load_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
- SB addr=0x21, wdata=0x12345678, ack after 3 wait cycles -> mem_wstrb=0010, mem_wdata=0x78787878, mem_req held 4 cycles, load_done 1 cycle, bus_err=0.
- LW with mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 WAIT cycles; load_done=1, bus_err=1, load_data=0. Reset asserted mid-WAIT -> mem_req=0 next cycle and no load_done pulse.
- LH addr=0x101: with LSU_MISALIGN_TRAP_EN -> no mem_req, load_done next cycle, bus_err=1. Without it -> bus access to 0x100, lane 0 halfword returned, bus_err=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store responder: one request at a time, req/ack memory bus, lane alignment and extension.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into bus errors.
module load_store_unit #(
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        load_done,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | bus request outstanding, waiting for mem_ack or timeout
    // S_DONE | one-cycle completion pulse, result/error valid
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [1:0]    r_lane;
    logic [CW-1:0] r_cnt;

    logic        w_accept;
    logic        w_legal;
    logic        w_misalign;
    logic        w_trap;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign req_ready = (r_state == S_IDLE);
    assign load_done = (r_state == S_DONE);
    assign w_accept  = req_valid && (r_state == S_IDLE);

    assign w_legal = req_we ? (req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010)
                            : (req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010 ||
                               req_funct3 == 3'b100 || req_funct3 == 3'b101);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_trap    = !w_legal || w_misalign;
    assign w_timeout = (r_state == S_WAIT) && !mem_ack && (r_cnt == '0);

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = 8'h0;
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_trap ? S_DONE : S_WAIT;
            S_WAIT:  if (mem_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_lane    <= 2'b00;
            r_cnt     <= '0;
            bus_err   <= 1'b0;
            load_data <= RESET_DATA;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_lane   <= req_addr[1:0];
                        if (w_trap) begin
                            bus_err   <= 1'b1;
                            load_data <= RESET_DATA;
                        end else begin
                            bus_err   <= 1'b0;
                            r_cnt     <= CNT_LOAD;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= w_wdata;
                            mem_wstrb <= w_wstrb;
                        end
                    end
                end
                S_WAIT: begin
                    // ack wins over a timeout landing on the same cycle
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b0;
                        load_data <= r_we ? RESET_DATA : w_ext;
                    end else if (w_timeout) begin
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        load_data <= RESET_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
